regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter_if.sv | 24 ++
 rtl/regfile_write_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback requester bundle: two valid/ready write channels (A = ALU, B = load)
// feeding the register-file write arbiter.
interface regfile_write_arbiter_if;
  logic        a_valid_i;
  logic [4:0]  a_addr_i;
  logic [31:0] a_data_i;
  logic        a_ready_o;
  logic        b_valid_i;
  logic [4:0]  b_addr_i;
  logic [31:0] b_data_i;
  logic        b_ready_o;

  // requester side
  modport master (
    output a_valid_i, a_addr_i, a_data_i, b_valid_i, b_addr_i, b_data_i,
    input  a_ready_o, b_ready_o
  );

  // arbiter side
  modport slave (
    input  a_valid_i, a_addr_i, a_data_i, b_valid_i, b_addr_i, b_data_i,
    output a_ready_o, b_ready_o
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: two writeback FIFOs drained round-robin onto a
// single registered write port, with combinational RAW hazard lookup.
// Optional feature macro: REGARB_FWD_EN adds output-stage forwarding ports.

// Per-requester FIFO with full/empty from a count register and per-entry
// address match for hazard detection.
module regarb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] data_i,
  input  logic        pop_i,
  input  logic [4:0]  rsaddr_i,
  input  logic [4:0]  rtaddr_i,
  output logic        full_o,
  output logic        nonempty_o,
  output logic [4:0]  head_addr_o,
  output logic [31:0] head_data_o,
  output logic        rs_hit_o,
  output logic        rt_hit_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][4:0]  addr_q, addr_d;
  logic [DEPTH-1:0][31:0] data_q, data_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          off;

  assign full_o      = (cnt_q == CW'(DEPTH));
  assign nonempty_o  = (cnt_q != '0);
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

  // next-state: write at tail, advance head on pop; pointers wrap naturally
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push_i) begin
      addr_d[wr_ptr_q] = addr_i;
      data_d[wr_ptr_q] = data_i;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop_i) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  end

  // an entry is live when its distance from the head is below the count
  always_comb begin
    rs_hit_o = 1'b0;
    rt_hit_o = 1'b0;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if ({1'b0, off} < cnt_q) begin
        if (rsaddr_i != 5'd0 && addr_q[i] == rsaddr_i) rs_hit_o = 1'b1;
        if (rtaddr_i != 5'd0 && addr_q[i] == rtaddr_i) rt_hit_o = 1'b1;
      end
    end
  end

  // FIFO state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      data_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

module regfile_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  regfile_write_arbiter_if.slave req,
  input  logic [4:0]  rsaddr_i,
  input  logic [4:0]  rtaddr_i,
  output logic        rs_hazard_o,
  output logic        rt_hazard_o,
  output logic        regwrite_o,
  output logic [4:0]  writeaddr_o,
  output logic [31:0] writedata_o,
`ifdef REGARB_FWD_EN
  output logic        rs_fwd_hit_o,
  output logic        rt_fwd_hit_o,
  output logic [31:0] fwd_data_o,
`endif
  output logic        busy_o
);
  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} grant_e;

  grant_e      last_grant_q, last_grant_d;
  logic        regwrite_q, regwrite_d;
  logic [4:0]  writeaddr_q, writeaddr_d;
  logic [31:0] writedata_q, writedata_d;

  logic        a_full, a_ne, a_rs, a_rt, push_a, grant_a;
  logic        b_full, b_ne, b_rs, b_rt, push_b, grant_b;
  logic [4:0]  a_head_addr, b_head_addr;
  logic [31:0] a_head_data, b_head_data;
  logic        out_rs, out_rt;

  // ready depends only on registered count, so a full FIFO never accepts
  assign req.a_ready_o = !rst_i && !a_full;
  assign req.b_ready_o = !rst_i && !b_full;
  assign push_a = req.a_valid_i && req.a_ready_o;
  assign push_b = req.b_valid_i && req.b_ready_o;

  regarb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk_i, .rst_i, .push_i(push_a), .addr_i(req.a_addr_i), .data_i(req.a_data_i),
    .pop_i(grant_a), .rsaddr_i, .rtaddr_i, .full_o(a_full), .nonempty_o(a_ne),
    .head_addr_o(a_head_addr), .head_data_o(a_head_data), .rs_hit_o(a_rs), .rt_hit_o(a_rt)
  );

  regarb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk_i, .rst_i, .push_i(push_b), .addr_i(req.b_addr_i), .data_i(req.b_data_i),
    .pop_i(grant_b), .rsaddr_i, .rtaddr_i, .full_o(b_full), .nonempty_o(b_ne),
    .head_addr_o(b_head_addr), .head_data_o(b_head_data), .rs_hit_o(b_rs), .rt_hit_o(b_rt)
  );

  // round-robin grant: ties go to the requester not granted last
  always_comb begin
    grant_a      = a_ne && (!b_ne || last_grant_q == LAST_B);
    grant_b      = b_ne && (!a_ne || last_grant_q == LAST_A);
    last_grant_d = last_grant_q;
    if (grant_a) last_grant_d = LAST_A;
    if (grant_b) last_grant_d = LAST_B;
  end

  // output stage: load granted head; r0 writes are consumed but never enabled
  always_comb begin
    regwrite_d  = 1'b0;
    writeaddr_d = writeaddr_q;
    writedata_d = writedata_q;
    if (grant_a) begin
      writeaddr_d = a_head_addr;
      writedata_d = a_head_data;
      regwrite_d  = (a_head_addr != 5'd0);
    end else if (grant_b) begin
      writeaddr_d = b_head_addr;
      writedata_d = b_head_data;
      regwrite_d  = (b_head_addr != 5'd0);
    end
  end

  // arbiter state and registered write port
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= LAST_B;
      regwrite_q   <= 1'b0;
      writeaddr_q  <= '0;
      writedata_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      regwrite_q   <= regwrite_d;
      writeaddr_q  <= writeaddr_d;
      writedata_q  <= writedata_d;
    end
  end

  assign regwrite_o  = regwrite_q;
  assign writeaddr_o = writeaddr_q;
  assign writedata_o = writedata_q;

  assign out_rs      = regwrite_q && rsaddr_i != 5'd0 && writeaddr_q == rsaddr_i;
  assign out_rt      = regwrite_q && rtaddr_i != 5'd0 && writeaddr_q == rtaddr_i;
  assign rs_hazard_o = a_rs || b_rs || out_rs;
  assign rt_hazard_o = a_rt || b_rt || out_rt;
  assign busy_o      = a_ne || b_ne || regwrite_q;

`ifdef REGARB_FWD_EN
  // the register file has no write-through, so the output stage is bypassable
  assign rs_fwd_hit_o = out_rs;
  assign rt_fwd_hit_o = out_rt;
  assign fwd_data_o   = writedata_q;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: queue-level reference model,
// random and directed writeback traffic, async reset mid-operation.
module tb_regfile_write_arbiter;
  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rsaddr = '0, rtaddr = '0;
  logic        rs_hz, rt_hz, regwrite, busy;
  logic [4:0]  waddr;
  logic [31:0] wdata;
`ifdef REGARB_FWD_EN
  logic        rs_fwd, rt_fwd;
  logic [31:0] fwd_data;
`endif

  regfile_write_arbiter_if rif ();

  regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .req(rif.slave),
    .rsaddr_i(rsaddr), .rtaddr_i(rtaddr),
    .rs_hazard_o(rs_hz), .rt_hazard_o(rt_hz),
    .regwrite_o(regwrite), .writeaddr_o(waddr), .writedata_o(wdata),
`ifdef REGARB_FWD_EN
    .rs_fwd_hit_o(rs_fwd), .rt_fwd_hit_o(rt_fwd), .fwd_data_o(fwd_data),
`endif
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // reference model state
  ent_t        qa[$], qb[$];
  exp_t        expq[$];
  bit          last_was_a;
  bit          out_wr;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  bit          a_stall, b_stall;
  int          cyc;
  int          n_chk, n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit hz(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (qa[i]) if (qa[i].addr == a) return 1'b1;
    foreach (qb[i]) if (qb[i].addr == a) return 1'b1;
    return out_wr && out_addr == a;
  endfunction

  task automatic model_reset();
    qa.delete(); qb.delete(); expq.delete();
    last_was_a = 1'b0; out_wr = 1'b0; out_addr = '0; out_data = '0;
    a_stall = 1'b0; b_stall = 1'b0;
  endtask

  // one rising edge: grant from pre-edge contents, then enqueue accepted offers
  task automatic model_step();
    bit   acc_a, acc_b, ga, gb;
    ent_t e;
    cyc++;
    acc_a = rif.a_valid_i && qa.size() < DEPTH;
    acc_b = rif.b_valid_i && qb.size() < DEPTH;
    ga = qa.size() > 0 && (qb.size() == 0 || !last_was_a);
    gb = !ga && qb.size() > 0;
    out_wr = 1'b0;
    if (ga || gb) begin
      e = ga ? qa.pop_front() : qb.pop_front();
      last_was_a = ga;
      out_addr = e.addr; out_data = e.data;
      out_wr = (e.addr != 5'd0);
      if (out_wr) expq.push_back('{addr: e.addr, data: e.data, cyc: cyc});
    end
    if (acc_a) qa.push_back('{addr: rif.a_addr_i, data: rif.a_data_i});
    if (acc_b) qb.push_back('{addr: rif.b_addr_i, data: rif.b_data_i});
    a_stall = rif.a_valid_i && !acc_a;
    b_stall = rif.b_valid_i && !acc_b;
  endtask

  // one cycle: offer new requests (stalled ones are held), check comb outputs
  task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic [4:0] rs, input logic [4:0] rt);
    @(negedge clk);
    if (!a_stall) begin rif.a_valid_i = av; rif.a_addr_i = aa; rif.a_data_i = ad; end
    if (!b_stall) begin rif.b_valid_i = bv; rif.b_addr_i = ba; rif.b_data_i = bd; end
    rsaddr = rs; rtaddr = rt;
    #1;
    chk("a_ready", rif.a_ready_o, qa.size() < DEPTH);
    chk("b_ready", rif.b_ready_o, qb.size() < DEPTH);
    chk("rs_hazard", rs_hz, hz(rs));
    chk("rt_hazard", rt_hz, hz(rt));
    chk("busy", busy, qa.size() > 0 || qb.size() > 0 || out_wr);
`ifdef REGARB_FWD_EN
    chk("rs_fwd_hit", rs_fwd, out_wr && rs != 0 && out_addr == rs);
    chk("rt_fwd_hit", rt_fwd, out_wr && rt != 0 && out_addr == rt);
    if (out_wr) chk("fwd_data", fwd_data, out_data);
`endif
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n, input logic [4:0] rs);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, rs, 5'd0);
  endtask

  // monitor: every enabled write must be the oldest expected one, on its cycle
  always @(negedge clk) begin
    exp_t e;
    if (!rst && regwrite === 1'b1) begin
      if (expq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL spurious_write: got addr %0d data %h expected no write", waddr, wdata);
      end else begin
        e = expq.pop_front();
        chk("write_addr", {27'd0, waddr}, {27'd0, e.addr});
        chk("write_data", wdata, e.data);
        chk("write_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    rif.a_valid_i = 0; rif.a_addr_i = 0; rif.a_data_i = 0;
    rif.b_valid_i = 0; rif.b_addr_i = 0; rif.b_data_i = 0;
    model_reset();

    // reset state
    rst = 1'b1;
    #1;
    chk("rst_a_ready", rif.a_ready_o, 1'b0);
    chk("rst_regwrite", regwrite, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_a_ready", rif.a_ready_o, 1'b1);
    chk("post_rst_b_ready", rif.b_ready_o, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_waddr", {27'd0, waddr}, 32'd0);
    chk("post_rst_wdata", wdata, 32'd0);

    // single A write, then idle so busy returns low
    step(1, 5'd5, 32'h1234_5678, 0, 0, 0, 5'd5, 5'd0);
    idle(4, 5'd5);

    // r0 write is consumed silently, no hazard on r0
    step(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 5'd0, 5'd0);
    idle(3, 5'd0);

    // pending B write to r7 watched by rs until it retires
    step(0, 0, 0, 1, 5'd7, 32'hCAFE_0007, 5'd7, 5'd7);
    idle(4, 5'd7);

    // back-to-back dual traffic: fills both FIFOs, alternates A/B
    for (int i = 1; i <= 4; i++)
      step(1, 5'(i), 32'hA000_0000 + i, 1, 5'(8 + i), 32'hB000_0000 + i, 5'(i), 5'(8 + i));
    idle(10, 5'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 60, 5'($urandom_range(0, 9)), $urandom,
           $urandom_range(0, 99) < 60, 5'($urandom_range(0, 9)), $urandom,
           5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
    idle(8, 5'd0);

    // saturate, then reset asynchronously mid-cycle with everything in flight
    for (int i = 0; i < 6; i++)
      step(1, 5'(16 + i), $urandom, 1, 5'(24 + i), $urandom, 5'd0, 5'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_regwrite", regwrite, 1'b0);
    chk("arst_waddr", {27'd0, waddr}, 32'd0);
    chk("arst_wdata", wdata, 32'd0);
    chk("arst_a_ready", rif.a_ready_o, 1'b0);
    chk("arst_b_ready", rif.b_ready_o, 1'b0);
    chk("arst_busy", busy, 1'b0);
    model_reset();
    rif.a_valid_i = 0; rif.b_valid_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // first tie after reset must go to A
    step(1, 5'd3, 32'h0000_AAAA, 1, 5'd4, 32'h0000_BBBB, 5'd3, 5'd4);
    idle(5, 5'd0);

    @(negedge clk);
    chk("scoreboard_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
